// File: rtl/aes_mix_columns_seq.sv
// Iterative AES MixColumns: one shared single-column unit walks the four columns of a state.
// Optional macro AES_MIX_COLUMNS_SEQ_FSM_CHECK_EN: sparse FSM encoding plus sticky err_o.

package aes_pkg;

  typedef enum logic [1:0] {
    CIPH_FWD = 2'b01,
    CIPH_INV = 2'b10
  } ciph_op_e;

`ifdef AES_MIX_COLUMNS_SEQ_FSM_CHECK_EN
  // Pairwise Hamming distance >= 3 so a single upset never lands on another legal state.
  typedef enum logic [5:0] {
    MCS_IDLE = 6'b001110,
    MCS_BUSY = 6'b110101,
    MCS_DONE = 6'b101000
  } mcs_fsm_e;
`else
  typedef enum logic [1:0] {
    MCS_IDLE = 2'b00,
    MCS_BUSY = 2'b01,
    MCS_DONE = 2'b10
  } mcs_fsm_e;
`endif

endpackage

module aes_mix_single_column
  import aes_pkg::*;
(
  input  ciph_op_e         op_i,
  input  logic [3:0][7:0]  data_i,
  output logic [3:0][7:0]  data_o
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row result for coefficient row (2,3,1,1) applied to a0..a3.
  function automatic logic [7:0] fwd_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    return xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
  endfunction

  // Row result for coefficient row (14,11,13,9) applied to a0..a3.
  function automatic logic [7:0] inv_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] x2_0, x4_0, x8_0;
    logic [7:0] x2_1, x8_1;
    logic [7:0] x4_2, x8_2;
    logic [7:0] x8_3;
    x2_0 = xt(a0);
    x4_0 = xt(x2_0);
    x8_0 = xt(x4_0);
    x2_1 = xt(a1);
    x8_1 = xt(xt(x2_1));
    x4_2 = xt(xt(a2));
    x8_2 = xt(x4_2);
    x8_3 = xt(xt(xt(a3)));
    return (x8_0 ^ x4_0 ^ x2_0) ^ (x8_1 ^ x2_1 ^ a1) ^ (x8_2 ^ x4_2 ^ a2) ^ (x8_3 ^ a3);
  endfunction

  logic [3:0][7:0] fwd_col;
  logic [3:0][7:0] inv_col;

  always_comb begin
    fwd_col[0] = fwd_byte(data_i[0], data_i[1], data_i[2], data_i[3]);
    fwd_col[1] = fwd_byte(data_i[1], data_i[2], data_i[3], data_i[0]);
    fwd_col[2] = fwd_byte(data_i[2], data_i[3], data_i[0], data_i[1]);
    fwd_col[3] = fwd_byte(data_i[3], data_i[0], data_i[1], data_i[2]);
    inv_col[0] = inv_byte(data_i[0], data_i[1], data_i[2], data_i[3]);
    inv_col[1] = inv_byte(data_i[1], data_i[2], data_i[3], data_i[0]);
    inv_col[2] = inv_byte(data_i[2], data_i[3], data_i[0], data_i[1]);
    inv_col[3] = inv_byte(data_i[3], data_i[0], data_i[1], data_i[2]);
  end

  // Anything that is not an explicit inverse request mixes forward.
  always_comb begin
    case (op_i)
      CIPH_INV: data_o = inv_col;
      default:  data_o = fwd_col;
    endcase
  end

endmodule

// state    | meaning
// MCS_IDLE | ready for a new state, state_o holds last result (or zero after scrub)
// MCS_BUSY | mixing column col_q this cycle, write-back into state_q
// MCS_DONE | result valid, waiting for out_ready_i
module aes_mix_columns_seq
  import aes_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  ciph_op_e              op_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0][3:0][7:0]  state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [3:0][3:0][7:0]  state_o,
  output logic                  err_o
);

  mcs_fsm_e             fsm_q, fsm_d;
  logic [3:0][3:0][7:0] state_q, state_d;
  ciph_op_e             op_q, op_d;
  logic [1:0]           col_q, col_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [3:0][7:0]      col_mixed;
  logic                 fsm_bad;

  aes_mix_single_column u_col (
    .op_i   (op_q),
    .data_i (state_q[col_q]),
    .data_o (col_mixed)
  );

  always_comb begin
    case (fsm_q)
      MCS_IDLE, MCS_BUSY, MCS_DONE: fsm_bad = 1'b0;
      default:                      fsm_bad = 1'b1;
    endcase
    if (fsm_q != MCS_BUSY && col_q != 2'd0) begin
      fsm_bad = 1'b1;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    op_d    = op_q;
    col_d   = col_q;

    // Abort and integrity failure share the same scrub path.
    if (clear_i || fsm_bad) begin
      fsm_d   = MCS_IDLE;
      state_d = '0;
      op_d    = CIPH_FWD;
      col_d   = 2'd0;
    end else begin
      case (fsm_q)
        MCS_IDLE: begin
          if (in_valid_i) begin
            state_d = state_i;
            op_d    = op_i;
            col_d   = 2'd0;
            fsm_d   = MCS_BUSY;
          end
        end
        MCS_BUSY: begin
          state_d[col_q] = col_mixed;
          col_d          = col_q + 2'd1;
          if (col_q == 2'd3) begin
            fsm_d = MCS_DONE;
          end
        end
        MCS_DONE: begin
          if (out_ready_i) begin
            fsm_d = MCS_IDLE;
          end
        end
        default: fsm_d = MCS_IDLE;
      endcase
    end

    in_ready_d  = (fsm_d == MCS_IDLE);
    out_valid_d = (fsm_d == MCS_DONE);
  end

`ifdef AES_MIX_COLUMNS_SEQ_FSM_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | fsm_bad;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q       <= MCS_IDLE;
      state_q     <= '0;
      op_q        <= CIPH_FWD;
      col_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      op_q        <= op_d;
      col_q       <= col_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: GF(2^8) matrix model with per-cycle compare plus directed vectors.
// Define AES_MIX_COLUMNS_SEQ_FSM_CHECK_EN to also exercise the integrity-error path.

module tb_aes_mix_columns_seq;
  import aes_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  ciph_op_e     op_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] state_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] state_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic         started = 1'b0;
  logic         chk_en  = 1'b0;
  int           m_phase = 0;
  logic [127:0] m_state   = '0;
  logic [127:0] m_pending = '0;

  always #5 clk_i = ~clk_i;

  aes_mix_columns_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .op_i        (op_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .state_i     (state_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .state_o     (state_o),
    .err_o       (err_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - r + 4) % 4], s[c*32 + k*8 +: 8]);
        end
        o[c*32 + r*8 +: 8] = acc;
      end
    end
    return o;
  endfunction

  // Column written as r0 r1 r2 r3 from the most significant byte down.
  function automatic logic [31:0] cw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] st(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2, input logic [31:0] w3);
    return {cw(w3), cw(w2), cw(w1), cw(w0)};
  endfunction

  task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: latency-level view of the block (accept, 4 busy cycles, done until drained).
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      started = 1'b1;
      m_phase = 0;
      m_state = '0;
    end else if (clear_i) begin
      m_phase = 0;
      m_state = '0;
    end else if (m_phase == 0) begin
      if (in_valid_i) begin
        m_pending = mix_model(state_i, op_i == CIPH_INV);
        m_phase   = 1;
      end
    end else if (m_phase < 4) begin
      m_phase = m_phase + 1;
    end else if (m_phase == 4) begin
      m_phase = 5;
      m_state = m_pending;
    end else if (out_ready_i) begin
      m_phase = 0;
    end
  end

  always @(negedge clk_i) begin
    if (started && chk_en) begin
      check_bit("cyc_in_ready", in_ready_o, m_phase == 0);
      check_bit("cyc_out_valid", out_valid_o, m_phase == 5);
      check_bit("cyc_err", err_o, 1'b0);
      if (m_phase == 0 || m_phase == 5) check_vec("cyc_state_o", state_o, m_state);
    end
  end

  // Called at a negedge; returns at the negedge where out_valid_o is first seen.
  task automatic send(input logic [127:0] s, input ciph_op_e op, output int lat);
    int n;
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_bit("send_in_ready", in_ready_o, 1'b1);
    state_i    = s;
    op_i       = op;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check_bit("send_out_valid", out_valid_o, 1'b1);
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fwd_in, fwd_out, mix_in, mix_out, held;
    int lat;

    fwd_in  = st(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
    fwd_out = st(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
    mix_in  = st(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
    mix_out = st(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);

    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    op_i        = CIPH_FWD;
    state_i     = '0;

    check_vec("model_fwd_literal", mix_model(fwd_in, 1'b0), fwd_out);
    check_vec("model_mix_literal", mix_model(mix_in, 1'b0), mix_out);
    check_vec("model_inv_literal", mix_model(mix_out, 1'b1), mix_in);

    repeat (2) @(negedge clk_i);
    check_bit("rst_in_ready", in_ready_o, 1'b1);
    check_bit("rst_out_valid", out_valid_o, 1'b0);
    check_vec("rst_state_o", state_o, '0);
    check_bit("rst_err", err_o, 1'b0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    send(fwd_in, CIPH_FWD, lat);
    check_int("fwd_latency", lat, 5);
    check_vec("fwd_result", state_o, fwd_out);
    drain();
    check_bit("fwd_back_idle", in_ready_o, 1'b1);

    send(mix_in, CIPH_FWD, lat);
    check_vec("mix_fwd_result", state_o, mix_out);
    drain();
    send(mix_out, CIPH_INV, lat);
    check_int("inv_latency", lat, 5);
    check_vec("inv_roundtrip", state_o, mix_in);
    drain();

    send(mix_in, CIPH_FWD, lat);
    held       = state_o;
    in_valid_i = 1'b1;
    state_i    = fwd_in;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check_bit("bp_out_valid", out_valid_o, 1'b1);
      check_bit("bp_in_ready", in_ready_o, 1'b0);
      check_vec("bp_state_stable", state_o, held);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check_bit("bp_release_idle", in_ready_o, 1'b1);
    check_bit("bp_release_valid", out_valid_o, 1'b0);

    state_i    = mix_in;
    op_i       = CIPH_FWD;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    check_bit("clr_in_ready", in_ready_o, 1'b1);
    check_bit("clr_out_valid", out_valid_o, 1'b0);
    check_vec("clr_state_o", state_o, '0);
    repeat (6) @(negedge clk_i);
    check_bit("clr_no_valid_later", out_valid_o, 1'b0);
    send(fwd_in, CIPH_FWD, lat);
    check_vec("post_clr_result", state_o, fwd_out);
    drain();

    send(mix_in, CIPH_FWD, lat);
    rst_ni  = 1'b0;
    clear_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_bit("rstpri_in_ready", in_ready_o, 1'b1);
    check_bit("rstpri_out_valid", out_valid_o, 1'b0);
    check_vec("rstpri_state_o", state_o, '0);
    check_bit("rstpri_err", err_o, 1'b0);
    rst_ni  = 1'b1;
    clear_i = 1'b0;

    send(mix_in, ciph_op_e'(2'b11), lat);
    check_vec("unsup_op3_fwd", state_o, mix_out);
    drain();
    send(mix_out, ciph_op_e'(2'b00), lat);
    check_vec("unsup_op0_fwd", state_o, mix_model(mix_out, 1'b0));
    drain();

`ifdef AES_MIX_COLUMNS_SEQ_FSM_CHECK_EN
    send(mix_in, CIPH_FWD, lat);
    drain();
    chk_en = 1'b0;
    force dut.fsm_q = mcs_fsm_e'(6'b111111);
    @(posedge clk_i);
    #1;
    release dut.fsm_q;
    @(negedge clk_i);
    check_bit("fsmchk_err", err_o, 1'b1);
    check_bit("fsmchk_idle", in_ready_o, 1'b1);
    check_bit("fsmchk_no_valid", out_valid_o, 1'b0);
    check_vec("fsmchk_scrub", state_o, '0);
    repeat (3) @(negedge clk_i);
    check_bit("fsmchk_err_sticky", err_o, 1'b1);
    clear_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i = 1'b0;
    check_bit("fsmchk_err_after_clear", err_o, 1'b1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_bit("fsmchk_err_after_reset", err_o, 1'b0);
    chk_en = 1'b1;
    send(fwd_in, CIPH_FWD, lat);
    check_vec("fsmchk_recover", state_o, fwd_out);
    drain();
`endif

    repeat (3) @(negedge clk_i);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_seq.md
# aes_mix_columns_seq

Iterative AES MixColumns unit. It time-multiplexes one `aes_mix_single_column` instance over the four columns of a 128-bit state, processing one column per cycle. It sits between the ShiftRows output and the AddRoundKey input in area-optimised cipher-core variants, and uses valid/ready handshakes on both sides. The operation direction is latched per state, and an explicit clear aborts in-flight work and scrubs the data registers.

## Interface
- No parameters.
- `clk_i  input  1  clock; all state updates on rising edge`
- `rst_ni  input  1  reset, synchronous, active-low`
- `clear_i  input  1  synchronous abort and scrub; priority over handshakes`
- `op_i  input  aes_pkg::ciph_op_e  direction; sampled only on input handshake`
- `in_valid_i  input  1  state_i valid`
- `in_ready_o  output  1  block can accept a state`
- `state_i  input  [3:0][3:0][7:0]  state; state_i[c][r] = column c, row r`
- `out_valid_o  output  1  state_o holds a finished result`
- `out_ready_i  input  1  consumer accepts state_o`
- `state_o  output  [3:0][3:0][7:0]  result, same layout as state_i`
- `err_o  output  1  FSM/counter integrity error (sticky until reset)`

## Operation
- **Registers:**
  - `state_q` (128 b)
  - `op_q`
  - `col_q` (2 b)
  - FSM `fsm_q`: IDLE, BUSY, DONE
- **Datapath:**
  - The single-column instance receives `op_q` and `state_q[col_q]`.
  - In BUSY, its output is written back into `state_q[col_q]` each cycle.
  - `state_o = state_q`.
- **IDLE:**
  - `in_ready_o = 1`.
  - On `in_valid_i`: load `state_q <= state_i`, `op_q <= op_i`, `col_q <= 0`, and go to BUSY.
- **BUSY:**
  - `in_ready_o = 0`, `out_valid_o = 0`.
  - Each cycle writes column `col_q`, then `col_q <= col_q + 1`.
  - When column 3 is written, `col_q` wraps to 0 and the FSM goes to DONE.
- **DONE:**
  - `out_valid_o = 1`, and `state_o` is held stable.
  - On `out_ready_i`, go to IDLE.
  - `in_ready_o` stays 0 in DONE, so there is no same-cycle hand-over.
- **Unsupported `op_i`:** any value other than CIPH_FWD/CIPH_INV is latched as-is. The column unit then behaves as forward mix, which is its default mux branch. No error is raised for this.
- **clear_i:**
  - From any state: next state is IDLE, `state_q <= 0`, `col_q <= 0`, `op_q <= CIPH_FWD`.
  - A simultaneous `in_valid_i` or `out_ready_i` is ignored.
- **Reset (`!rst_ni`):** same effect as clear, and also clears `err_o`. Reset has priority over clear.
- **Invalid FSM encoding or `col_q != 0` outside BUSY:** next state is IDLE and the data is scrubbed as on clear.

## Timing
- **Reset values:** `in_ready_o = 1` (first cycle after reset), `out_valid_o = 0`, `state_o = 0`, `err_o = 0`.
- **Latency:**
  - Input handshake in cycle T.
  - BUSY in cycles T+1 to T+4 (columns 0, 1, 2, 3).
  - `out_valid_o` rises in cycle T+5.
- **Throughput:** one state per 6 cycles minimum (accept, 4× BUSY, DONE with immediate `out_ready_i`).
- **Output handshake:** `out_valid_o` does not drop without `out_ready_i`, except on clear or reset. `state_o` changes only in BUSY, on clear, or on reset.
- **Outputs:** all outputs are registered or decoded purely from registers. There are no combinational paths from inputs to outputs.

## Configuration
- **`AES_MIX_COLUMNS_SEQ_FSM_CHECK_EN` defined:**
  - FSM is sparsely encoded (Hamming distance ≥ 3; 6-bit codes).
  - Any non-legal code, or `col_q != 0` outside BUSY, sets `err_o` (sticky) and forces IDLE with a scrub.
- **Not defined:**
  - FSM uses a 2-bit binary encoding; the unused code decodes as IDLE.
  - `err_o` is tied to 0.
  - Functional behaviour is otherwise identical.

## Test plan
- **FWD vector:** every column = {r0..r3} db,13,53,45, `op_i` = FWD → after 5 cycles every column = 8e,4d,a1,bc, with `out_valid_o` first high exactly at T+5.
- **INV round-trip:** mixed columns db135345 / f20a225c / 01010101 / d4d4d4d5 with FWD give 8e4da1bc / 9fdc589d / 01010101 / d5d5d7d6. Feeding that result back with INV reproduces the original state.
- **Back-pressure:** hold `out_ready_i = 0` for 10 cycles in DONE → `state_o` and `out_valid_o` stay stable and `in_ready_o = 0`. Releasing `out_ready_i` returns the block to IDLE the next cycle.
- **Mid-operation clear:** assert `clear_i` in the 2nd BUSY cycle, with `in_valid_i` also high → next cycle IDLE, `state_o = 0`, no `out_valid_o`. A new state accepted afterwards gives the correct result.
- **Reset priority:** assert `rst_ni = 0` together with `clear_i` in DONE → next cycle all outputs are at their reset values.
- **With the macro, FSM-check:** force an illegal `fsm_q` code → `err_o = 1` and held high, FSM in IDLE, `state_o = 0`. Only `rst_ni` clears `err_o`. Without the macro, `err_o` stays 0 throughout.
